// File: rtl/ccip_c0_read_gate.sv
// ccip_c0_read_gate: credit-limited gate for CCI-P channel 0 read requests.
// Arbiter requests land in a 2-entry skid buffer and are issued one per cycle
// while the FIU has room and the outstanding-read count is below the limit.
// Returning responses release credits. A drain handshake lets the wrapper
// quiesce the channel.
module ccip_c0_read_gate #(
  parameter int MAX_OUTSTANDING = 64,
  parameter int ADDR_W          = 42,
  parameter int MDATA_W         = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [MDATA_W-1:0] req_mdata,
  output logic               c0tx_valid,
  output logic [ADDR_W-1:0]  c0tx_addr,
  output logic [MDATA_W-1:0] c0tx_mdata,
  input  logic               c0tx_almfull,
  input  logic               c0rx_rsp_valid,
  input  logic               drain_req,
  output logic               drained,
  output logic [7:0]         outstanding,
  output logic               rsp_underflow
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] LP_MAX = 8'(MAX_OUTSTANDING);

  state_t               r_state;
  state_t               w_state_nxt;

  logic [ADDR_W-1:0]    r_skid_addr  [2];
  logic [MDATA_W-1:0]   r_skid_mdata [2];
  logic                 r_rd_ptr;
  logic                 r_wr_ptr;
  logic [1:0]           r_skid_cnt;

  // Holds req_ready low until the first clock after reset release.
  logic                 r_open;

  logic                 r_c0tx_valid;
  logic [ADDR_W-1:0]    r_c0tx_addr;
  logic [MDATA_W-1:0]   r_c0tx_mdata;
  logic [7:0]           r_outstanding;
  logic                 r_underflow;
  logic                 r_drained;

  logic                 w_accept;
  logic                 w_issue;
  logic                 w_skid_empty;

  // Ready and issue decisions use only registered state plus almfull, so an
  // accept and a pop can never both hit a full skid in one cycle.
  assign w_skid_empty = (r_skid_cnt == 2'd0);
  assign req_ready    = r_open && (r_state == ST_RUN) && (r_skid_cnt != 2'd2);
  assign w_accept     = req_valid && req_ready;
  assign w_issue      = !w_skid_empty && !c0tx_almfull && (r_outstanding < LP_MAX);

  assign c0tx_valid    = r_c0tx_valid;
  assign c0tx_addr     = r_c0tx_addr;
  assign c0tx_mdata    = r_c0tx_mdata;
  assign outstanding   = r_outstanding;
  assign rsp_underflow = r_underflow;
  assign drained       = r_drained;

  // Opens the request port one clock after reset is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_open <= 1'b0;
    end else begin
      r_open <= 1'b1;
    end
  end

  // Skid payload storage; contents are only meaningful while counted valid.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_skid_addr[r_wr_ptr]  <= req_addr;
      r_skid_mdata[r_wr_ptr] <= req_mdata;
    end
  end

  // Skid pointers and occupancy; accept and pop together keep the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_skid_cnt <= 2'd0;
    end else begin
      if (w_accept) r_wr_ptr <= ~r_wr_ptr;
      if (w_issue)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_accept, w_issue})
        2'b10:   r_skid_cnt <= r_skid_cnt + 2'd1;
        2'b01:   r_skid_cnt <= r_skid_cnt - 2'd1;
        default: r_skid_cnt <= r_skid_cnt;
      endcase
    end
  end

  // Registers the popped head onto the FIU request; payload holds between issues.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_c0tx_valid <= 1'b0;
      r_c0tx_addr  <= '0;
      r_c0tx_mdata <= '0;
    end else begin
      r_c0tx_valid <= w_issue;
      if (w_issue) begin
        r_c0tx_addr  <= r_skid_addr[r_rd_ptr];
        r_c0tx_mdata <= r_skid_mdata[r_rd_ptr];
      end
    end
  end

  // Outstanding-read credit counter with sticky underflow on a stray response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_outstanding <= 8'd0;
      r_underflow   <= 1'b0;
    end else begin
      if (c0rx_rsp_valid && (r_outstanding == 8'd0)) r_underflow <= 1'b1;
      case ({w_issue, c0rx_rsp_valid})
        2'b10:   r_outstanding <= r_outstanding + 8'd1;
        2'b01:   if (r_outstanding != 8'd0) r_outstanding <= r_outstanding - 8'd1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Drain FSM state register; drained mirrors entry into DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_RUN;
      r_drained <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_drained <= (w_state_nxt == ST_DONE);
    end
  end

  // Drain FSM next-state: quiesce once nothing is buffered or in flight.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (drain_req) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!drain_req) begin
          w_state_nxt = ST_RUN;
        end else if (w_skid_empty && (r_outstanding == 8'd0) && !w_issue) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!drain_req) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

endmodule
